// File: rtl/blinker_pkg.sv
// Shared constants and helpers for the LED blinker.
package blinker_pkg;

    // Roughly half a second at 50 MHz.
    localparam int DEFAULT_HALF_PERIOD = 25_000_000;

    // Bits needed to hold 0 .. half_period-1 (ceil(log2)), never below one bit.
    function automatic int blinker_cnt_width(input int half_period);
        int width;
        width = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(half_period)) begin
                width = i + 1;
            end
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/blinker_sync_2ff.sv
// Two-flop synchronizer for slow asynchronous level inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First stage may go metastable; the second stage gives it a cycle to settle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/blinker_top_entity_0.sv
// LED blinker: toggles the LED every HALF_PERIOD enabled clock cycles.
// The enable is synchronized first; dropping it pauses the count in place.
module blinker_top_entity_0
    import blinker_pkg::*;
#(
    parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD,
    parameter int CNT_WIDTH   = blinker_cnt_width(HALF_PERIOD)
) (
    input  logic system1000,
    input  logic system1000_rstn,
    input  logic eta_i1,
    output logic topLet_o
);

    // Terminal count; HALF_PERIOD=1 makes this 0 so every enabled cycle toggles.
    localparam logic [CNT_WIDTH-1:0] CNT_TERM = CNT_WIDTH'(HALF_PERIOD - 1);

    logic                 en_s;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 led_q;
    logic                 led_d;

    // Bring the asynchronous enable into the system1000 domain.
    sync_2ff #(
        .WIDTH (1)
    ) u_en_sync (
        .clk_i (system1000),
        .rst_i (system1000_rstn),
        .d_i   (eta_i1),
        .q_o   (en_s)
    );

    // Next count/LED: count up while enabled, clear and toggle at terminal, hold when paused.
    always_comb begin
        cnt_d = cnt_q;
        led_d = led_q;
        if (en_s) begin
            if (cnt_q == CNT_TERM) begin
                cnt_d = '0;
                led_d = ~led_q;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Counter and LED state, cleared immediately by the asynchronous reset.
    always_ff @(posedge system1000 or posedge system1000_rstn) begin
        if (system1000_rstn) begin
            cnt_q <= '0;
            led_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    assign topLet_o = led_q;

endmodule

// File: tb/tb_blinker_top_entity_0.sv
// Directed bench for the LED blinker: one instance with HALF_PERIOD=4 and one
// with HALF_PERIOD=1, driven from the same clock, reset and enable.
`timescale 1ns/1ps
module tb_blinker_top_entity_0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic eta = 1'b0;
    logic led4;
    logic led1;

    int checks = 0;
    int errors = 0;

    // Expected values on edges 1..14 after reset release with the enable held high.
    int exp_led4_run[14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    int exp_cnt4_run[14] = '{0, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    int exp_led1_run[14] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};

    blinker_top_entity_0 #(
        .HALF_PERIOD (4)
    ) dut4 (
        .system1000      (clk),
        .system1000_rstn (rst),
        .eta_i1          (eta),
        .topLet_o        (led4)
    );

    blinker_top_entity_0 #(
        .HALF_PERIOD (1)
    ) dut1 (
        .system1000      (clk),
        .system1000_rstn (rst),
        .eta_i1          (eta),
        .topLet_o        (led1)
    );

    // Clock: period 1000.
    initial begin
        forever #500 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two-unit reset pulse; outputs must clear before any clock edge.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_led4"}, 32'(led4), 0);
        check({tag, "_cnt4"}, 32'(dut4.cnt_q), 0);
        check({tag, "_led1"}, 32'(led1), 0);
        #1;
        rst = 1'b0;
    endtask

    // Walk n edges after release with the enable high, checking the HALF_PERIOD=4 instance.
    task automatic run_from_release(input string tag, input int n);
        for (int e = 0; e < n; e++) begin
            step();
            check($sformatf("%s_led_e%0d", tag, e + 1), 32'(led4), exp_led4_run[e]);
            check($sformatf("%s_cnt_e%0d", tag, e + 1), 32'(dut4.cnt_q), exp_cnt4_run[e]);
        end
    endtask

    initial begin
        // Reset with the enable low, then idle for 100 cycles.
        eta = 1'b0;
        #1;
        pulse_reset("por");
        for (int i = 0; i < 100; i++) begin
            step();
            check($sformatf("idle_led_%0d", i), 32'(led4), 0);
            check($sformatf("idle_cnt_%0d", i), 32'(dut4.cnt_q), 0);
        end

        // Release with the enable high: rise at edge 6, fall at 10, rise at 14.
        pulse_reset("rst_run");
        eta = 1'b1;
        for (int e = 0; e < 14; e++) begin
            step();
            check($sformatf("run_led_e%0d", e + 1), 32'(led4), exp_led4_run[e]);
            check($sformatf("run_cnt_e%0d", e + 1), 32'(dut4.cnt_q), exp_cnt4_run[e]);
            check($sformatf("hp1_led_e%0d", e + 1), 32'(led1), exp_led1_run[e]);
            check($sformatf("hp1_cnt_e%0d", e + 1), 32'(dut1.cnt_q), 0);
        end

        // Edges 15..17 bring cnt to 3 with the LED still high.
        step();
        step();
        step();
        check("pre_rst_led", 32'(led4), 1);
        check("pre_rst_cnt", 32'(dut4.cnt_q), 3);

        // Mid-count reset clears without a clock; timing restarts from scratch.
        pulse_reset("mid_rst");
        run_from_release("restart", 6);

        // Pause at cnt=2: enable drops after edge 2, so edges 3 and 4 still count.
        pulse_reset("rst_pause");
        eta = 1'b1;
        run_from_release("pause_pre", 2);
        eta = 1'b0;
        run_from_release("pause_tail", 0);
        step();
        check("pause_e3_cnt", 32'(dut4.cnt_q), 1);
        step();
        check("pause_e4_cnt", 32'(dut4.cnt_q), 2);
        for (int i = 0; i < 18; i++) begin
            step();
            check($sformatf("paused_led_%0d", i), 32'(led4), 0);
            check($sformatf("paused_cnt_%0d", i), 32'(dut4.cnt_q), 2);
        end
        // Resume: two edges of sync latency, then 2 -> 3 -> clear with toggle.
        eta = 1'b1;
        step();
        check("resume_k0_cnt", 32'(dut4.cnt_q), 2);
        step();
        check("resume_k1_cnt", 32'(dut4.cnt_q), 2);
        step();
        check("resume_k2_cnt", 32'(dut4.cnt_q), 3);
        check("resume_k2_led", 32'(led4), 0);
        step();
        check("resume_k3_cnt", 32'(dut4.cnt_q), 0);
        check("resume_k3_led", 32'(led4), 1);

        // Enable drop timed so en_s is low on the terminal-count edge: toggle suppressed.
        step();
        check("term_k4_cnt", 32'(dut4.cnt_q), 1);
        eta = 1'b0;
        step();
        check("term_k5_cnt", 32'(dut4.cnt_q), 2);
        step();
        check("term_k6_cnt", 32'(dut4.cnt_q), 3);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("term_hold_cnt_%0d", i), 32'(dut4.cnt_q), 3);
            check($sformatf("term_hold_led_%0d", i), 32'(led4), 1);
        end
        eta = 1'b1;
        step();
        check("term_m0_cnt", 32'(dut4.cnt_q), 3);
        step();
        check("term_m1_cnt", 32'(dut4.cnt_q), 3);
        check("term_m1_led", 32'(led4), 1);
        step();
        check("term_m2_cnt", 32'(dut4.cnt_q), 0);
        check("term_m2_led", 32'(led4), 0);

        // Single-cycle enable pulse: exactly one increment, two edges after capture.
        eta = 1'b0;
        pulse_reset("rst_pulse");
        step();
        step();
        step();
        eta = 1'b1;
        step();
        eta = 1'b0;
        check("pulse_j1_cnt", 32'(dut4.cnt_q), 0);
        step();
        check("pulse_j2_cnt", 32'(dut4.cnt_q), 0);
        step();
        check("pulse_j3_cnt", 32'(dut4.cnt_q), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("pulse_hold_cnt_%0d", i), 32'(dut4.cnt_q), 1);
            check($sformatf("pulse_hold_led_%0d", i), 32'(led4), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blinker_top_entity_0.md
BLINKER_TOP_ENTITY_0 -- requirements
Module: blinker_top_entity_0

Interface
REQ-001 Parameter HALF_PERIOD, default 25_000_000: enabled clock cycles per LED half-period; legal range 1 to 2^31-1.
REQ-002 Parameter CNT_WIDTH, default clog2(HALF_PERIOD) with a minimum of 1: counter width, derived and not overridden.
REQ-003 system1000  input  1  single system clock; all state updates on its rising edge.
REQ-004 system1000_rstn  input  1  asynchronous active-high reset.
REQ-005 eta_i1  input  1  blink enable, asynchronous to the clock domain; 1 = count/blink, 0 = pause.
REQ-006 topLet_o  output  1  LED drive, taken directly from a flop with no combinational path.

Function
REQ-007 eta_i1 SHALL pass through a 2-flop synchronizer; en_s is the second flop's output.
REQ-008 Counter cnt[CNT_WIDTH-1:0] and LED flop led SHALL be the only other state; topLet_o = led.
REQ-009 With en_s=1 and cnt != HALF_PERIOD-1, the block SHALL increment cnt by 1 and hold led.
REQ-010 With en_s=1 and cnt == HALF_PERIOD-1, the block SHALL clear cnt to 0 and invert led in the same cycle.
REQ-011 With en_s=0, cnt and led SHALL hold (pause, not clear); counting resumes from the held cnt.
REQ-012 Latency: eta_i1 rising before clock edge k gives en_s=1 after edge k+1; the first cnt increment occurs at edge k+2.
REQ-013 From reset release with eta_i1 held at 1, the first led toggle SHALL occur on the (HALF_PERIOD+2)th rising edge; later toggles occur every HALF_PERIOD edges.
REQ-014 Output period while enabled SHALL be exactly 2*HALF_PERIOD cycles at 50% duty.
REQ-015 HALF_PERIOD=1: led SHALL toggle on every enabled cycle and cnt SHALL stay 0.
REQ-016 cnt SHALL never exceed HALF_PERIOD-1; there is no wrap other than the terminal clear.
REQ-017 An enable drop on the terminal-count cycle (en_s=0 at that edge) SHALL suppress the toggle; the toggle occurs on the next enabled cycle.

Reset
REQ-018 While system1000_rstn=1, sync flops, cnt and led SHALL clear to 0 immediately, with no clock required; topLet_o=0.
REQ-019 Reset asserted mid-count SHALL discard the partial count; after release, timing follows REQ-013.
REQ-020 Reset release SHALL be synchronous to system1000 by integration; no internal release synchronizer.

Structure
REQ-021 Package blinker_pkg SHALL hold a clog2-based width function and the default HALF_PERIOD constant.
REQ-022 Sub-module sync_2ff (parameterized width, async reset to 0) SHALL implement REQ-007.
REQ-023 The top SHALL contain the counter/toggle logic only; no latches and no derived clocks.

Verification (HALF_PERIOD=4, clock period 1000, reset pulse of 2 time units)
REQ-024 Reset with eta_i1=0 for 100 cycles -> topLet_o constantly 0, cnt constantly 0.
REQ-025 Release reset with eta_i1=1 -> topLet_o rises at edge 6, falls at edge 10, rises at edge 14 (period 8, 50% duty).
REQ-026 eta_i1=1 to cnt=2, then 0 for 20 cycles, then 1 -> topLet_o frozen during pause; toggles 2 cycles after en_s returns (cnt 2→3→clear).
REQ-027 Assert reset while topLet_o=1 and cnt=3 -> topLet_o=0 without a clock edge; restart timing per REQ-025.
REQ-028 HALF_PERIOD=1 with eta_i1=1 -> topLet_o toggles every cycle from edge 3.
REQ-029 eta_i1 pulse of 1 cycle between edges -> exactly one cnt increment, seen 2 cycles later.
